link_transmitter: RTL and testbench
===================================

Name: link_transmitter

Overview:
- Serial link source that feeds the slave-side receiver over the LINK_CLK domain.
- Accepts parallel frames through a valid/ready handshake into a one-entry holding buffer.
- Serializes each frame bit 0 first on S_OUT and raises SYNC during the final bit, so the receiver captures the whole frame on that edge.
- Supports back-to-back frames and a configurable idle gap.

Parameters:
WIDTH, 49, frame width in bits; bit 0 is sent first, bit WIDTH-1 last.
GAP, 0, idle cycles inserted after each frame before the next bit 0 (0..255).
IDLE_LEVEL, 1'b0, S_OUT level when no frame is being shifted.

Ports:
LINK_CLK  in  1  link clock, rising-edge.
RESETN  in  1  asynchronous active-low reset.
DATA_IN  in  [0:WIDTH-1]  frame to send; index 0 goes out first.
DATA_VALID  in  1  DATA_IN valid.
DATA_READY  out  1  holding buffer empty; the frame is accepted on an edge where VALID&READY.
S_OUT  out  1  serial data, registered.
SYNC  out  1  high exactly during the cycle S_OUT carries bit WIDTH-1, registered.
BUSY  out  1  high while in SHIFT or GAP, or while the buffer is full.
TX_DONE  out  1  one-cycle pulse after the last bit of a frame completes.
FRAME_CNT  out  8  count of completed frames, wraps 255->0.

Behaviour:
- Reset (async, RESETN=0):
  - S_OUT=IDLE_LEVEL, SYNC=0, TX_DONE=0, FRAME_CNT=0.
  - Buffer empty, so DATA_READY=1 and BUSY=0.
  - State IDLE, bit counter 0, gap counter 0.
- DATA_READY = not buf_full (from register, no combinational path from DATA_VALID).
- Accept: on an edge with DATA_VALID&DATA_READY, the buffer loads DATA_IN and buf_full=1. DATA_IN is not sampled otherwise.
- States IDLE, SHIFT, GAP.
- IDLE:
  - S_OUT=IDLE_LEVEL, SYNC=0.
  - On an edge with buf_full=1: shift register loads the buffer, buf_full clears, S_OUT takes bit 0, bit counter=0, next state SHIFT.
- SHIFT:
  - Each edge advances the counter and drives the next bit.
  - SYNC is driven 1 together with bit WIDTH-1, 0 otherwise.
  - On the edge ending bit WIDTH-1: TX_DONE=1 for one cycle, FRAME_CNT increments.
  - Then:
    - If GAP>0: go to GAP, S_OUT=IDLE_LEVEL, SYNC=0.
    - Else if buf_full: reload directly. Bit 0 of the next frame immediately follows bit WIDTH-1, with no dead cycle.
    - Else: go to IDLE.
- GAP:
  - Holds S_OUT=IDLE_LEVEL, SYNC=0 for exactly GAP cycles.
  - Then behaves as the IDLE reload decision: load if buf_full, else IDLE.
- Latency: frame accepted at edge t0 with shifter idle:
  - Bit i is driven from edge t0+1+i to edge t0+2+i.
  - SYNC is high between edges t0+WIDTH and t0+WIDTH+1.
  - Downstream RECV_OK is high after edge t0+WIDTH+1 (t0+50 for WIDTH=49).
- Buffer refill during SHIFT is allowed. Load to shifter and new accept cannot coincide on one edge, because READY=0 whenever the buffer is full.
- Holding DATA_VALID with READY=0 has no effect; the data must be held until accepted.
- Reset mid-frame: the output returns to IDLE_LEVEL with SYNC=0 immediately. The partial frame and any buffered frame are discarded and never completed. No SYNC is emitted, so the receiver produces no RECV_OK for it.
- FRAME_CNT wraps 255->0 with TX_DONE still pulsing.
- SYNC is never high on two consecutive cycles when WIDTH>1.

Test Plan:
- Reset, then one frame 49'h1_2345_6789_ABCD, GAP=0, accepted at t0 -> bits appear bit 0 first. SYNC is high only in cycle t0+49 to t0+50 with S_OUT=bit 48. A connected receiver shows DATA_OUT=49'h1_2345_6789_ABCD and RECV_OK=1 for one cycle after edge t0+50. FRAME_CNT=1.
- Two frames presented back-to-back with VALID held, GAP=0 -> second bit 0 directly follows first bit 48. SYNC pulses 49 cycles apart. READY drops after the second accept and rises again when the second frame loads. FRAME_CNT=2.
- GAP=3, two queued frames -> exactly 3 IDLE_LEVEL cycles between SYNC of frame 1 and bit 0 of frame 2. TX_DONE pulses twice.
- VALID asserted while the buffer is full -> DATA_IN changes are ignored until READY=1. The transmitted frame equals the data present on the accepting edge.
- RESETN pulsed low during bit 20 -> S_OUT=IDLE_LEVEL and SYNC=0 immediately, FRAME_CNT=0. The receiver never asserts RECV_OK. The next frame sent transmits correctly.
- Send 256 frames -> FRAME_CNT reads 0 after frame 256, and TX_DONE has pulsed 256 times.

Source files
------------

// File: rtl/link_transmitter.sv
// Serial link source: one-entry holding buffer feeding a shift register that sends
// frames bit 0 first, with SYNC marking the final bit and an optional idle gap.
module link_transmitter #(
  parameter int   WIDTH      = 49,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             LINK_CLK,
  input  logic             RESETN,
  input  logic [0:WIDTH-1] DATA_IN,
  input  logic             DATA_VALID,
  output logic             DATA_READY,
  output logic             S_OUT,
  output logic             SYNC,
  output logic             BUSY,
  output logic             TX_DONE,
  output logic [7:0]       FRAME_CNT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

  state_e           state_q, state_d;
  logic [0:WIDTH-1] buf_q, buf_d;
  logic             full_q, full_d;
  logic [0:WIDTH-1] sh_q, sh_d, sh_nx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic             sout_q, sout_d;
  logic             sync_q, sync_d;
  logic             done_q, done_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic             load;

  always_ff @(posedge LINK_CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      full_q  <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      sout_q  <= IDLE_LEVEL;
      sync_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      sout_q  <= sout_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    full_d  = full_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    sout_d  = IDLE_LEVEL;
    sync_d  = 1'b0;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    load    = 1'b0;
    sh_nx   = sh_q << 1;

    case (state_q)
      ST_IDLE: begin
        if (full_q) load = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST) begin
          done_d = 1'b1;
          fcnt_d = fcnt_q + 8'd1;
          if (GAP > 0) begin
            state_d = ST_GAP;
            gcnt_d  = '0;
          end else if (full_q) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d  = cnt_q + CW'(1);
          sh_d   = sh_nx;
          sout_d = sh_nx[0];
          sync_d = ((cnt_q + CW'(1)) == LAST);
        end
      end
      ST_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          if (full_q) load = 1'b1;
          else        state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reload drains the buffer; it never coincides with an accept since READY is low while full.
    if (load) begin
      state_d = ST_SHIFT;
      sh_d    = buf_q;
      sout_d  = buf_q[0];
      sync_d  = (WIDTH == 1);
      cnt_d   = '0;
      full_d  = 1'b0;
    end
    if (DATA_VALID && !full_q) begin
      buf_d  = DATA_IN;
      full_d = 1'b1;
    end
  end

  assign DATA_READY = !full_q;
  assign BUSY       = (state_q != ST_IDLE) || full_q;
  assign S_OUT      = sout_q;
  assign SYNC       = sync_q;
  assign TX_DONE    = done_q;
  assign FRAME_CNT  = fcnt_q;

endmodule

// File: tb/tb_link_transmitter.sv
// Bench for link_transmitter: two instances (GAP=0 idle-low, GAP=3 idle-high) checked
// each cycle against a frame-schedule model (start = max(accept+1, prev_end+GAP)).
module tb_link_transmitter;
  localparam int W = 49;

  logic clk = 1'b0, rstn = 1'b0;
  logic [0:W-1] din0 = '0, din3 = '0;
  logic vld0 = 1'b0, vld3 = 1'b0;
  logic rdy0, sout0, sync0, busy0, done0, rdy3, sout3, sync3, busy3, done3;
  logic [7:0] cnt0, cnt3;
  logic [12:0] obs0, obs3;

  link_transmitter #(.WIDTH(W), .GAP(0), .IDLE_LEVEL(1'b0)) u0 (
    .LINK_CLK(clk), .RESETN(rstn), .DATA_IN(din0), .DATA_VALID(vld0), .DATA_READY(rdy0),
    .S_OUT(sout0), .SYNC(sync0), .BUSY(busy0), .TX_DONE(done0), .FRAME_CNT(cnt0));
  link_transmitter #(.WIDTH(W), .GAP(3), .IDLE_LEVEL(1'b1)) u3 (
    .LINK_CLK(clk), .RESETN(rstn), .DATA_IN(din3), .DATA_VALID(vld3), .DATA_READY(rdy3),
    .S_OUT(sout3), .SYNC(sync3), .BUSY(busy3), .TX_DONE(done3), .FRAME_CNT(cnt3));

  assign obs0 = {sout0, sync0, done0, rdy0, busy0, cnt0};
  assign obs3 = {sout3, sync3, done3, rdy3, busy3, cnt3};

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0, cyc = 0;
  int   gapv[2] = '{0, 3};
  logic idl[2]  = '{1'b0, 1'b1};
  logic [0:W-1] frm[2][300];
  int   fst[2][300];
  int   nf[2] = '{0, 0};
  logic [0:W-1] q0[$], q3[$];
  logic jitter = 1'b0;
  logic e_sout[2], e_sync[2], e_done[2], e_busy[2];
  logic e_rdy[2] = '{1'b1, 1'b1};
  logic [7:0] e_cnt[2];

  function automatic logic [12:0] ev(int d);
    return {e_sout[d], e_sync[d], e_done[d], e_rdy[d], e_busy[d], e_cnt[d]};
  endfunction

  function automatic logic [0:W-1] rnd_frame();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Present the queue head; while the model says the buffer is full, optionally scramble DATA_IN.
  task automatic drive();
    vld0 = (q0.size() > 0);
    din0 = (q0.size() == 0) ? '0 : (e_rdy[0] || !jitter) ? q0[0] : rnd_frame();
    vld3 = (q3.size() > 0);
    din3 = (q3.size() == 0) ? '0 : (e_rdy[1] || !jitter) ? q3[0] : rnd_frame();
  endtask

  // One link clock: drive, update the schedule model on the edge, compute expectations, return at negedge.
  task automatic step();
    bit acc[2];
    logic [0:W-1] cap[2];
    int s, c;
    drive();
    acc[0] = rstn && vld0 && e_rdy[0];
    acc[1] = rstn && vld3 && e_rdy[1];
    cap[0] = din0;
    cap[1] = din3;
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rstn) nf[d] = 0;
      else if (acc[d] && nf[d] < 300) begin
        s = cyc + 1;
        if (nf[d] > 0 && fst[d][nf[d]-1] + W + gapv[d] > s) s = fst[d][nf[d]-1] + W + gapv[d];
        fst[d][nf[d]] = s;
        frm[d][nf[d]] = cap[d];
        nf[d]++;
        if (d == 0) void'(q0.pop_front());
        else        void'(q3.pop_front());
      end
      e_sout[d] = idl[d]; e_sync[d] = 1'b0; e_done[d] = 1'b0; c = 0;
      e_rdy[d]  = !(nf[d] > 0 && fst[d][nf[d]-1] > cyc);
      e_busy[d] = !e_rdy[d];
      for (int k = 0; k < nf[d]; k++) begin
        s = fst[d][k];
        if (cyc >= s && cyc < s + W) begin
          e_sout[d] = frm[d][k][cyc - s];
          e_sync[d] = (cyc == s + W - 1);
        end
        if (cyc == s + W) e_done[d] = 1'b1;
        if (s + W <= cyc) c++;
        if (cyc >= s && cyc < s + W + gapv[d]) e_busy[d] = 1'b1;
      end
      e_cnt[d] = 8'(c);
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    q0.delete(); q3.delete(); jitter = 1'b0;
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    if (obs0 !== 13'b0_0_0_1_0_00000000) begin
      nfail++; $display("FAIL reset_u0 got=%b want=%b", obs0, 13'b0_0_0_1_0_00000000);
    end
    ncmp++;
    if (obs3 !== 13'b1_0_0_1_0_00000000) begin
      nfail++; $display("FAIL reset_u3 got=%b want=%b", obs3, 13'b1_0_0_1_0_00000000);
    end
    ncmp++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [0:W-1] f, rx, rxcap;
    int t0, sync_at, nsync;
    f = 49'h1_2345_6789_ABCD; rx = '0; rxcap = '0; sync_at = -1; nsync = 0;
    reset_dut();
    q0.push_back(f);
    t0 = cyc + 1;
    for (int i = 0; i < W + 5; i++) begin
      step();
      if (obs0 !== ev(0)) begin nfail++; $display("FAIL single cyc=%0d got=%b want=%b", cyc, obs0, ev(0)); end
      ncmp++;
      rx = {rx[1:W-1], sout0};
      if (sync0) begin rxcap = rx; sync_at = cyc; nsync++; end
    end
    if (rxcap !== f) begin nfail++; $display("FAIL single_frame got=%h want=%h", rxcap, f); end
    ncmp++;
    if (sync_at != t0 + W || nsync != 1) begin
      nfail++; $display("FAIL single_sync_edge got=%0d(n=%0d) want=%0d(n=1)", sync_at, nsync, t0 + W);
    end
    ncmp++;
    if (cnt0 !== 8'd1) begin nfail++; $display("FAIL single_cnt got=%0d want=1", cnt0); end
    ncmp++;
  endtask

  task automatic test_back_to_back();
    int sy[$];
    int t0;
    reset_dut();
    q0.push_back(rnd_frame()); q0.push_back(rnd_frame());
    t0 = cyc + 1;
    for (int i = 0; i < 2 * W + 6; i++) begin
      step();
      if (obs0 !== ev(0)) begin nfail++; $display("FAIL b2b cyc=%0d got=%b want=%b", cyc, obs0, ev(0)); end
      ncmp++;
      if (sync0) sy.push_back(cyc);
    end
    if (sy.size() != 2 || sy[0] != t0 + W || sy[1] - sy[0] != W) begin
      nfail++; $display("FAIL b2b_sync_spacing got_n=%0d want_n=2 first=%0d want=%0d", sy.size(),
                        (sy.size() > 0) ? sy[0] : -1, t0 + W);
    end
    ncmp++;
    if (cnt0 !== 8'd2) begin nfail++; $display("FAIL b2b_cnt got=%0d want=2", cnt0); end
    ncmp++;
  endtask

  task automatic test_gap();
    int sy[$];
    int nd;
    nd = 0;
    reset_dut();
    q3.push_back(rnd_frame()); q3.push_back(rnd_frame());
    for (int i = 0; i < 2 * W + 12; i++) begin
      step();
      if (obs3 !== ev(1)) begin nfail++; $display("FAIL gap cyc=%0d got=%b want=%b", cyc, obs3, ev(1)); end
      ncmp++;
      if (sync3) sy.push_back(cyc);
      if (done3) nd++;
    end
    if (sy.size() != 2 || sy[1] - sy[0] != W + 3) begin
      nfail++; $display("FAIL gap_spacing got_n=%0d want_n=2 diff=%0d want=%0d", sy.size(),
                        (sy.size() == 2) ? sy[1] - sy[0] : -1, W + 3);
    end
    ncmp++;
    if (nd != 2 || cnt3 !== 8'd2) begin
      nfail++; $display("FAIL gap_done got=%0d/%0d want=2/2", nd, cnt3);
    end
    ncmp++;
  endtask

  task automatic test_hold();
    logic [0:W-1] fr[3];
    logic [0:W-1] rx;
    int k;
    k = 0; rx = '0;
    reset_dut();
    jitter = 1'b1;
    for (int i = 0; i < 3; i++) begin fr[i] = rnd_frame(); q0.push_back(fr[i]); end
    for (int i = 0; i < 3 * W + 8; i++) begin
      step();
      if (obs0 !== ev(0)) begin nfail++; $display("FAIL hold cyc=%0d got=%b want=%b", cyc, obs0, ev(0)); end
      ncmp++;
      rx = {rx[1:W-1], sout0};
      if (sync0 && k < 3) begin
        if (rx !== fr[k]) begin nfail++; $display("FAIL hold_frame%0d got=%h want=%h", k, rx, fr[k]); end
        ncmp++;
        k++;
      end
    end
    if (k != 3) begin nfail++; $display("FAIL hold_frames_seen got=%0d want=3", k); end
    ncmp++;
    jitter = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [0:W-1] f3, rx;
    int t0, nsync, k;
    rx = '0; nsync = 0; k = 0;
    reset_dut();
    q0.push_back(rnd_frame()); q0.push_back(rnd_frame());
    t0 = cyc + 1;
    // frame 2 starts at t0+1+W; stop once its bit 20 is on the wire
    for (int i = 0; i < 200 && cyc < t0 + W + 21; i++) begin
      step();
      if (obs0 !== ev(0)) begin nfail++; $display("FAIL rmid_pre cyc=%0d got=%b want=%b", cyc, obs0, ev(0)); end
      ncmp++;
    end
    rstn = 1'b0;
    #1;
    if ({sout0, sync0, cnt0} !== 10'b0) begin
      nfail++; $display("FAIL rmid_immediate got=%b want=%b", {sout0, sync0, cnt0}, 10'b0);
    end
    ncmp++;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (obs0 !== ev(0)) begin nfail++; $display("FAIL rmid_post cyc=%0d got=%b want=%b", cyc, obs0, ev(0)); end
      ncmp++;
      if (sync0) nsync++;
    end
    if (nsync != 0) begin nfail++; $display("FAIL rmid_sync got=%0d want=0", nsync); end
    ncmp++;
    f3 = rnd_frame();
    q0.push_back(f3);
    for (int i = 0; i < W + 5; i++) begin
      step();
      if (obs0 !== ev(0)) begin nfail++; $display("FAIL rmid_next cyc=%0d got=%b want=%b", cyc, obs0, ev(0)); end
      ncmp++;
      rx = {rx[1:W-1], sout0};
      if (sync0) begin
        k++;
        if (rx !== f3) begin nfail++; $display("FAIL rmid_frame got=%h want=%h", rx, f3); end
        ncmp++;
      end
    end
    if (k != 1 || cnt0 !== 8'd1) begin nfail++; $display("FAIL rmid_next_cnt got=%0d/%0d want=1/1", k, cnt0); end
    ncmp++;
  endtask

  task automatic test_wrap();
    int nd;
    nd = 0;
    reset_dut();
    for (int i = 0; i < 256; i++) q0.push_back(rnd_frame());
    for (int i = 0; i < 256 * W + 10; i++) begin
      step();
      if (obs0 !== ev(0)) begin nfail++; $display("FAIL wrap cyc=%0d got=%b want=%b", cyc, obs0, ev(0)); end
      ncmp++;
      if (done0) nd++;
    end
    if (nd != 256 || cnt0 !== 8'd0) begin
      nfail++; $display("FAIL wrap_final done=%0d cnt=%0d want 256/0", nd, cnt0);
    end
    ncmp++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_hold();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
